// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: controller states and
// the {QR[0],Q} pair values that select add or subtract.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: optional add/sub of BR into AC,
// then an arithmetic right shift of the {AC,QR,Q} chain.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   i_ac,
    input  logic [WIDTH:0]   i_br,
    input  logic [WIDTH-1:0] i_qr,
    input  logic             i_q,
    output logic [WIDTH:0]   o_ac,
    output logic [WIDTH-1:0] o_qr,
    output logic             o_q
);

    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum = i_ac;
        case ({i_qr[0], i_q})
            OP_ADD:  w_sum = i_ac + i_br;
            OP_SUB:  w_sum = i_ac - i_br;
            default: w_sum = i_ac;
        endcase
    end

    // AC sign bit is replicated; the bit falling out of AC enters QR.
    assign o_ac = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign o_qr = {w_sum[0], i_qr[WIDTH-1:1]};
    assign o_q  = i_qr[0];

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential signed Booth multiplier: one Booth step per clock for WIDTH
// clocks, then a one-cycle done pulse with the 2*WIDTH-bit product held.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    logic [WIDTH:0]     r_ac;
    logic [WIDTH:0]     r_br;
    logic [WIDTH-1:0]   r_qr;
    logic               r_q;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH:0]     w_ac;
    logic [WIDTH-1:0]   w_qr;
    logic               w_q;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .i_ac (r_ac),
        .i_br (r_br),
        .i_qr (r_qr),
        .i_q  (r_q),
        .o_ac (w_ac),
        .o_qr (w_qr),
        .o_q  (w_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ac      <= '0;
            r_br      <= '0;
            r_qr      <= '0;
            r_q       <= 1'b0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_ac    <= '0;
                        r_qr    <= multiplier;
                        r_q     <= 1'b0;
                        r_br    <= {multiplicand[WIDTH-1], multiplicand};
                        r_count <= CNT_W'(WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_ac    <= w_ac;
                    r_qr    <= w_qr;
                    r_q     <= w_q;
                    r_count <= r_count - 1'b1;
                    // Last step: capture the step output directly so product is valid in DONE.
                    if (r_count == CNT_W'(1)) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_product <= {w_ac[WIDTH-1:0], w_qr};
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult (WIDTH=4): directed cases, ignored
// starts, mid-run reset, back-to-back and a shuffled sweep of all operand pairs.
module tb_booth_seq_mult;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int vectors;
    int miscompares;

    booth_seq_mult #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed integer multiplication, truncated to 2*W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int pa;
        int pb;
        pa = int'($signed(a));
        pb = int'($signed(b));
        return (2*W)'(pa * pb);
    endfunction

    // Called at a falling edge with the DUT idle; returns at the falling edge
    // of the first idle cycle after DONE, so a following call is back-to-back.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
        logic [2*W-1:0] expv;
        expv         = ref_mul(a, b);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        for (int c = 1; c <= W + 1; c++) begin
            @(negedge clk);
            start        = inject && (c == 2 || c == W + 1);
            multiplicand = W'($urandom);
            multiplier   = W'($urandom);
            check("busy_run", 16'(busy), 16'd1);
            check("done_run", 16'(done), 16'(c == W + 1));
            if (c == W + 1)
                check("product", 16'(product), 16'(expv));
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after", 16'(busy), 16'd0);
        check("done_after", 16'(done), 16'd0);
        check("product_held", 16'(product), 16'(expv));
    endtask

    initial begin
        int order[256];
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_product", 16'(product), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 16'(busy), 16'd0);

        // Directed products, also compared with hand-computed constants.
        run_op(4'h3, 4'h2, 1'b0);
        check("const_3x2", 16'(product), 16'h06);
        run_op(4'hD, 4'h5, 1'b0);
        check("const_m3x5", 16'(product), 16'hF1);
        run_op(4'h7, 4'h8, 1'b0);
        check("const_7xm8", 16'(product), 16'hC8);
        run_op(4'h8, 4'h8, 1'b0);
        check("const_m8xm8", 16'(product), 16'h40);

        // Starts pulsed during RUN and DONE must be ignored.
        run_op(4'h5, 4'h6, 1'b1);
        check("const_ignored", 16'(product), 16'h1E);
        repeat (2) @(negedge clk);
        check("ignored_idle_busy", 16'(busy), 16'd0);
        check("ignored_held", 16'(product), 16'h1E);

        // Asynchronous reset in cycle 3 of a run.
        multiplicand = 4'h6;
        multiplier   = 4'h3;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 16'(busy), 16'd0);
        check("abort_done", 16'(done), 16'd0);
        check("abort_product", 16'(product), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(negedge clk);
            check("abort_no_done", 16'(done), 16'd0);
        end
        check("abort_product_kept", 16'(product), 16'd0);
        run_op(4'h6, 4'hB, 1'b0);
        check("const_6xm5", 16'(product), 16'hE2);

        // Back-to-back followed by a shuffled sweep of every operand pair.
        run_op(4'h2, 4'h7, 1'b0);
        run_op(4'hF, 4'hF, 1'b0);
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j;
            int t;
            j        = int'($urandom_range(i, 0));
            t        = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 256; i++)
            run_op(W'(order[i] >> 4), W'(order[i]), (i % 17) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
